// File: rtl/mem_access.sv
// Memory-access pipeline stage: pass-through for ALU ops, req/ack bus
// transaction with timeout for loads and stores, little-endian lane handling.
module mem_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_reg2,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack
);
  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t        state_q, state_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [7:0]    op_q, op_d;
  logic [1:0]    lane_q, lane_d;

  logic          is_load, is_store, is_mem, misaligned;
  logic [3:0]    sel_calc;
  logic [31:0]   wdata_calc;
  logic [31:0]   rd_shift;
  logic [15:0]   rd_half;
  logic [31:0]   load_val;
  logic          unused_stall;

  assign unused_stall = ^{stall[5], stall[3:0]};

  // Decode of the op currently presented by EX/MEM
  always_comb begin
    is_load    = (mem_aluop == OP_LB) || (mem_aluop == OP_LH) || (mem_aluop == OP_LW) ||
                 (mem_aluop == OP_LBU) || (mem_aluop == OP_LHU);
    is_store   = (mem_aluop == OP_SB) || (mem_aluop == OP_SH) || (mem_aluop == OP_SW);
    is_mem     = is_load || is_store;
    misaligned = (((mem_aluop == OP_LH) || (mem_aluop == OP_LHU) || (mem_aluop == OP_SH)) &&
                  mem_addr[0]) ||
                 (((mem_aluop == OP_LW) || (mem_aluop == OP_SW)) && (mem_addr[1:0] != 2'b00));
    sel_calc   = 4'b1111;
    wdata_calc = mem_reg2;
    case (mem_aluop)
      OP_LB, OP_LBU, OP_SB: begin
        sel_calc   = 4'b0001 << mem_addr[1:0];
        wdata_calc = {4{mem_reg2[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        sel_calc   = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{mem_reg2[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane extraction uses the op/lane latched at request time
  always_comb begin
    rd_shift = rdata_q >> {lane_q, 3'b000};
    rd_half  = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (op_q)
      OP_LB:   load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
      OP_LBU:  load_val = {24'h0, rd_shift[7:0]};
      OP_LH:   load_val = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_val = {16'h0, rd_half};
      default: load_val = rdata_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      sel_q   <= 4'h0;
      wdata_q <= 32'h0;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      op_q    <= 8'h0;
      lane_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      op_q    <= op_d;
      lane_q  <= lane_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    op_d    = op_q;
    lane_d  = lane_q;
    case (state_q)
      S_IDLE: begin
        if (is_mem && !misaligned) begin
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {mem_addr[31:2], 2'b00};
          sel_d   = sel_calc;
          wdata_d = wdata_calc;
          cnt_d   = '0;
          err_d   = 1'b0;
          op_d    = mem_aluop;
          lane_d  = mem_addr[1:0];
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        // Ack takes priority over a simultaneous timeout
        if (dbus_ack) begin
          rdata_d = dbus_rdata;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!stall[4]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wd_o       = mem_wd;
    wreg_o     = mem_wreg;
    wdata_o    = mem_wdata;
    stallreq   = 1'b0;
    misalign_o = 1'b0;
    bus_err_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_mem) begin
          wreg_o = 1'b0;
          if (misaligned) misalign_o = 1'b1;
          else            stallreq   = 1'b1;
        end
      end
      S_BUSY: begin
        stallreq = 1'b1;
        wreg_o   = 1'b0;
      end
      S_DONE: begin
        if (err_q) begin
          wreg_o    = 1'b0;
          bus_err_o = 1'b1;
        end else if (op_q == OP_LB || op_q == OP_LH || op_q == OP_LW ||
                     op_q == OP_LBU || op_q == OP_LHU) begin
          wdata_o = load_val;
        end
      end
      default: ;
    endcase
  end

  assign dbus_req   = req_q;
  assign dbus_we    = we_q;
  assign dbus_addr  = addr_q;
  assign dbus_sel   = sel_q;
  assign dbus_wdata = wdata_q;
endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus random
// transactions checked against a byte-arithmetic reference model.
module tb_mem_access;
  localparam int TO = 16;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_addr;
  logic [31:0] mem_reg2;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq;
  logic        misalign_o;
  logic        bus_err_o;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_wdata;
  logic [31:0] dbus_rdata;
  logic        dbus_ack;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_aluop(mem_aluop), .mem_addr(mem_addr), .mem_reg2(mem_reg2),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq(stallreq),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
    .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes (0 = not a memory op)
  function automatic int msize(input logic [7:0] op);
    case (op)
      8'hE0, 8'hE4, 8'hE8: return 1;
      8'hE1, 8'hE5, 8'hE9: return 2;
      8'hE3, 8'hEB:        return 4;
      default:             return 0;
    endcase
  endfunction

  function automatic bit m_store(input logic [7:0] op);
    return op >= 8'hE8;
  endfunction

  function automatic bit m_signed(input logic [7:0] op);
    return (op == 8'hE0) || (op == 8'hE1);
  endfunction

  function automatic longint unsigned m_mask(input int size);
    return (64'd1 << (8 * size)) - 64'd1;
  endfunction

  function automatic logic [31:0] m_sel(input int size, input logic [31:0] addr);
    return 32'(m_mask(size) >> (8 * (size - 1)) * 0) == 0 ? 32'h0 :
           32'(((longint'(1) << size) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input int size, input logic [31:0] v);
    longint unsigned r = 0;
    for (int i = 0; i < 4 / size; i++) r = r | ((longint'(v) & m_mask(size)) << (8 * size * i));
    return 32'(r);
  endfunction

  function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] addr,
                                         input logic [31:0] rd);
    int size = msize(op);
    longint unsigned v = (longint'(rd) >> (8 * (addr % 4))) & m_mask(size);
    if (m_signed(op) && v[8 * size - 1]) v = v | ~m_mask(size);
    return 32'(v);
  endfunction

  // One instruction through the stage; starts and ends 1 time unit after a rising edge.
  // ack_at: BUSY cycle (1-based) in which ack is given; 0 = never.
  task automatic run_op(input string nm, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] reg2, input logic [31:0] alu, input logic [4:0] wd,
                        input logic wreg, input int ack_at, input logic [31:0] rd, input int hold);
    int size = msize(op);
    int busy = 0;
    int stall_cnt = 0;
    bit fin = 0;
    bit timeout;
    logic [31:0] exp_wd;
    mem_aluop = op; mem_addr = addr; mem_reg2 = reg2; mem_wdata = alu;
    mem_wd = wd; mem_wreg = wreg; stall = 6'b0;
    if (size == 0) begin
      dbus_ack = 1'b1;
      #2;
      chk({nm, ".pass_wd"}, wd_o, wd);
      chk({nm, ".pass_wreg"}, wreg_o, wreg);
      chk({nm, ".pass_wdata"}, wdata_o, alu);
      chk({nm, ".pass_stallreq"}, stallreq, 0);
      @(posedge clk); #1;
      dbus_ack = 1'b0;
      chk({nm, ".pass_no_req"}, dbus_req, 0);
      $display("[TB] %s op=%h nonmem wdata=%h", nm, op, wdata_o);
      return;
    end
    if ((addr % size) != 0) begin
      #2;
      chk({nm, ".mis_flag"}, misalign_o, 1);
      chk({nm, ".mis_wreg"}, wreg_o, 0);
      chk({nm, ".mis_stallreq"}, stallreq, 0);
      @(posedge clk); #1;
      chk({nm, ".mis_no_req"}, dbus_req, 0);
      $display("[TB] %s op=%h addr=%h misaligned", nm, op, addr);
      return;
    end
    #2;
    chk({nm, ".idle_stallreq"}, stallreq, 1);
    chk({nm, ".idle_wreg"}, wreg_o, 0);
    if (stallreq) stall_cnt++;
    while (!fin) begin
      @(posedge clk); #1;
      busy++;
      chk({nm, ".busy_req"}, dbus_req, 1);
      if (busy == 1) begin
        chk({nm, ".addr"}, dbus_addr, {addr[31:2], 2'b00});
        chk({nm, ".sel"}, dbus_sel, m_sel(size, addr));
        chk({nm, ".we"}, dbus_we, m_store(op));
        if (m_store(op)) chk({nm, ".wdata"}, dbus_wdata, m_wdata(size, reg2));
      end
      dbus_ack   = (busy == ack_at);
      dbus_rdata = (busy == ack_at) ? rd : $urandom;
      #2;
      chk({nm, ".busy_wreg"}, wreg_o, 0);
      if (stallreq) stall_cnt++;
      fin = (busy == ack_at) || (busy >= TO);
    end
    timeout = !(ack_at >= 1 && ack_at <= TO);
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    stall[4] = (hold > 0);
    exp_wd = (!timeout && !m_store(op)) ? m_load(op, addr, rd) : alu;
    #2;
    chk({nm, ".stall_cycles"}, stall_cnt, 1 + (timeout ? TO : ack_at));
    chk({nm, ".done_stallreq"}, stallreq, 0);
    chk({nm, ".done_req"}, dbus_req, 0);
    chk({nm, ".done_err"}, bus_err_o, timeout);
    chk({nm, ".done_wreg"}, wreg_o, timeout ? 1'b0 : wreg);
    chk({nm, ".done_wd"}, wd_o, wd);
    if (!timeout) chk({nm, ".done_wdata"}, wdata_o, exp_wd);
    for (int h = 1; h <= hold; h++) begin
      dbus_ack = 1'b1;
      dbus_rdata = $urandom;
      @(posedge clk); #1;
      dbus_ack = 1'b0;
      if (h == hold) stall[4] = 1'b0;
      #2;
      chk({nm, ".hold_stallreq"}, stallreq, 0);
      chk({nm, ".hold_err"}, bus_err_o, timeout);
      if (!timeout) chk({nm, ".hold_wdata"}, wdata_o, exp_wd);
    end
    $display("[TB] %s op=%h addr=%h busy=%0d err=%0d wdata=%h", nm, op, addr, busy, timeout,
             wdata_o);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] mem_ops [8];
    logic [7:0] op;
    mem_ops = '{8'hE0, 8'hE1, 8'hE3, 8'hE4, 8'hE5, 8'hE8, 8'hE9, 8'hEB};
    rst = 1'b0; stall = 6'b0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
    mem_wd = 5'd0; mem_wreg = 1'b0; mem_wdata = 32'h0; mem_aluop = 8'h0;
    mem_addr = 32'h0; mem_reg2 = 32'h0;
    #3;
    chk("rst.req", dbus_req, 0);
    chk("rst.we", dbus_we, 0);
    chk("rst.sel", dbus_sel, 0);
    chk("rst.addr", dbus_addr, 0);
    chk("rst.wdata", dbus_wdata, 0);
    chk("rst.stallreq", stallreq, 0);
    chk("rst.wdata_o", wdata_o, 0);
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;

    run_op("t1_alu", 8'h25, 32'h0, 32'h0, 32'h1234, 5'd3, 1'b1, 0, 32'h0, 0);
    run_op("t2_lb",  8'hE0, 32'h103, 32'h0, 32'h0, 5'd7, 1'b1, 2, 32'h80FF_0000, 0);
    run_op("t2_lbu", 8'hE4, 32'h103, 32'h0, 32'h0, 5'd7, 1'b1, 2, 32'h80FF_0000, 0);
    run_op("t3_sh",  8'hE9, 32'h202, 32'hAAAA_BEEF, 32'h55, 5'd0, 1'b0, 1, 32'h0, 0);
    run_op("t4_lw",  8'hE3, 32'h5, 32'h0, 32'h0, 5'd4, 1'b1, 1, 32'h0, 0);
    run_op("t4_sh",  8'hE9, 32'h1, 32'h0, 32'h0, 5'd4, 1'b1, 1, 32'h0, 0);
    run_op("t5_to",  8'hE3, 32'h40, 32'h0, 32'h0, 5'd9, 1'b1, 0, 32'h0, 1);
    run_op("t5_ack16", 8'hE3, 32'h44, 32'h0, 32'h0, 5'd9, 1'b1, 16, 32'hCAFE_F00D, 0);
    run_op("t6_hold", 8'hE1, 32'h302, 32'h0, 32'h0, 5'd12, 1'b1, 1, 32'h8001_1234, 3);

    // Reset in the middle of a load
    mem_aluop = 8'hE3; mem_addr = 32'h80; mem_wreg = 1'b1; mem_wd = 5'd2;
    @(posedge clk); #1;
    chk("t6_rst.busy_req", dbus_req, 1);
    rst = 1'b0;
    #1;
    chk("t6_rst.req_drop", dbus_req, 0);
    chk("t6_rst.sel_clr", dbus_sel, 0);
    chk("t6_rst.addr_clr", dbus_addr, 0);
    mem_aluop = 8'h11; mem_wdata = 32'hDEAD_0001; mem_wd = 5'd6; mem_wreg = 1'b1;
    #1;
    chk("t6_rst.stallreq", stallreq, 0);
    chk("t6_rst.wdata", wdata_o, 32'hDEAD_0001);
    chk("t6_rst.err", bus_err_o, 0);
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst.after_req", dbus_req, 0);
    run_op("t6_post", 8'h11, 32'h0, 32'h0, 32'hDEAD_0002, 5'd6, 1'b1, 0, 32'h0, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) op = 8'($urandom_range(0, 8'hDF));
      else op = mem_ops[$urandom_range(0, 7)];
      run_op($sformatf("rnd%0d", i), op, $urandom, $urandom, $urandom, 5'($urandom),
             1'($urandom), ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5), $urandom,
             $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage of the five-stage pipeline. Sits directly downstream of the EX/MEM register and upstream of the MEM/WB register.
- Non-memory instructions pass through in the same cycle.
- Loads and stores run a request/acknowledge transaction on the data bus. A stall request is raised to the pipeline control block until the transaction completes.
- Load data is byte-lane extracted and sign- or zero-extended before write-back.

Parameters:
- TIMEOUT, 16: maximum number of BUSY cycles without dbus_ack before the access is aborted.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset; asynchronous, active-low (rst==0 resets).
- stall  in  6  pipeline stall vector from control; bit 4 = MEM/WB stage stalled.
- mem_wd  in  5  destination register address from EX/MEM.
- mem_wreg  in  1  register write enable from EX/MEM.
- mem_wdata  in  32  ALU result from EX/MEM.
- mem_aluop  in  8  operation code from EX/MEM.
- mem_addr  in  32  effective memory address.
- mem_reg2  in  32  store data (rt value).
- wd_o  out  5  destination address to MEM/WB.
- wreg_o  out  1  write enable to MEM/WB.
- wdata_o  out  32  write-back value to MEM/WB.
- stallreq  out  1  stall request to control.
- misalign_o  out  1  one-cycle flag: misaligned access suppressed.
- bus_err_o  out  1  one-cycle flag: bus timeout.
- dbus_req  out  1  bus request (registered).
- dbus_we  out  1  1 = write (registered).
- dbus_addr  out  32  word address; {mem_addr[31:2],2'b00} (registered).
- dbus_sel  out  4  byte-lane enables (registered).
- dbus_wdata  out  32  write data, replicated to lanes (registered).
- dbus_rdata  in  32  read data, valid while dbus_ack=1.
- dbus_ack  in  1  single-cycle completion pulse.

Behaviour:
- Opcodes:
  - LB=8'hE0, LH=8'hE1, LW=8'hE3, LBU=8'hE4, LHU=8'hE5.
  - SB=8'hE8, SH=8'hE9, SW=8'hEB.
  - Any other value is a non-memory op.
- Byte order is little-endian:
  - addr[1:0]=0..3 selects sel 0001/0010/0100/1000.
  - Halfword at addr[1]=0 → 0011; addr[1]=1 → 1100.
  - Word → 1111.
- SB replicates the byte ×4 on dbus_wdata; SH replicates the halfword ×2.
- Reset (async, rst=0), effective immediately:
  - state=IDLE; dbus_req=0, dbus_we=0, dbus_sel=0, dbus_addr=0, dbus_wdata=0.
  - Timeout counter=0; read latch=0.
  - Combinational outputs follow the IDLE rules. wd_o/wreg_o/wdata_o are 0 only when the inputs are 0.
- Reset mid-transaction drops dbus_req in the same instant. No completion is reported.
- State machine IDLE / BUSY / DONE.
- IDLE, non-memory op:
  - wd_o=mem_wd, wreg_o=mem_wreg, wdata_o=mem_wdata, combinational.
  - stallreq=0.
- IDLE, misaligned op (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0):
  - No bus access; wreg_o=0; misalign_o=1; stallreq=0; state stays IDLE.
- IDLE, aligned memory op:
  - stallreq=1 and wreg_o=0, combinational.
  - Next edge: latch bus signals, dbus_req=1, counter=0, go BUSY.
- BUSY:
  - stallreq=1; wreg_o=0; bus signals held stable.
  - Counter increments each cycle.
  - dbus_ack=1: capture dbus_rdata, dbus_req←0, go DONE.
  - Counter reaches TIMEOUT-1 without ack: dbus_req←0, error flag set, go DONE.
  - An ack arriving in the same cycle as the timeout wins; no error is flagged.
- DONE:
  - stallreq=0.
  - Load: wdata_o = extracted lane, sign-extended (LB/LH) or zero-extended (LBU/LHU/LW); wreg_o=mem_wreg.
  - Store: wreg_o=mem_wreg, wdata_o=mem_wdata.
  - Timeout: wreg_o=0 and bus_err_o=1.
  - Remain in DONE while stall[4]=1; otherwise go IDLE next edge.
- Latency: aligned access with ack in the first BUSY cycle occupies 3 cycles (IDLE, BUSY, DONE). Each extra wait cycle adds one.
- dbus_ack seen in IDLE or DONE is ignored.

Test Plan:
1. Non-memory op: aluop=8'h25, mem_wd=3, mem_wreg=1, mem_wdata=32'h1234 → same cycle wd_o=3, wreg_o=1, wdata_o=32'h1234; stallreq=0; dbus_req never rises.
2. LB at addr 32'h103, ack on the second BUSY cycle with rdata=32'h80FF_0000 → dbus_sel=1000, dbus_addr=32'h100; stallreq high for 3 cycles; DONE wdata_o=32'hFFFF_FF80, wreg_o=1. Repeat as LBU → 32'h0000_0080.
3. SH at addr 32'h202, reg2=32'hAAAA_BEEF, ack in the first BUSY cycle → dbus_we=1, dbus_sel=1100, dbus_wdata=32'hBEEF_BEEF; stallreq released after 2 cycles.
4. LW at addr 32'h5, then SH at addr 32'h1 → misalign_o=1 each, no bus request, wreg_o=0, stallreq=0.
5. LW with ack withheld (TIMEOUT=16) → dbus_req drops after 16 BUSY cycles; DONE bus_err_o=1, wreg_o=0. Ack in exactly cycle 16 → normal completion, no error.
6. Assert rst=0 during BUSY → dbus_req=0 immediately. After release with a non-memory op present → IDLE pass-through. stall[4]=1 during DONE holds wdata_o and stallreq=0 until it clears.
